fir_coef_bank: RTL and testbench



---
 rtl/fir_coef_bank_pkg.sv | 21 ++
 rtl/fir_coef_mask_tracker.sv | 36 +++
 rtl/fir_coef_bank.sv | 100 ++++++++++
 tb/tb_fir_coef_bank.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_coef_bank_pkg.sv
// Shared types for the FIR coefficient bank: tap count, coefficient widths,
// the packed I/Q coefficient struct and the load/commit FSM state encoding.
// Ports: none (package).
package fir_structs;

  localparam int NUM_COEF = 15;  // unique taps; tap 14 is the centre tap
  localparam int COEF_W   = 27;  // 3.24 signed
  localparam int ADDR_W   = 5;

  typedef struct packed {
    logic signed [COEF_W-1:0] I;
    logic signed [COEF_W-1:0] Q;
  } Coef;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PEND = 2'd2
  } state_t;

endpackage

// File: rtl/fir_coef_mask_tracker.sv
// Tracks which shadow taps have been written since the last commit and flags
// when the mask, including this cycle's write, covers every tap.
// Ports: clk/reset; wr + addr (accepted write); clr (commit); mask; full_next.
module fir_coef_mask_tracker
  import fir_structs::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                wr,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                clr,
  output logic [NUM_COEF-1:0] mask,
  output logic                full_next
);

  logic [NUM_COEF-1:0] mask_nxt;

  // wr is only raised for in-range addresses, so the compare loop doubles as
  // the address decoder without truncating addr.
  always_comb begin
    mask_nxt = mask;
    for (int k = 0; k < NUM_COEF; k++) begin
      if (wr && (addr == ADDR_W'(k))) mask_nxt[k] = 1'b1;
    end
    full_next = &mask_nxt;
  end

  // A commit clears the mask even if a write lands in the same cycle: that
  // write is forwarded into the committed set, not into the next load.
  always_ff @(posedge clk) begin
    if (reset)    mask <= '0;
    else if (clr) mask <= '0;
    else          mask <= mask_nxt;
  end

endmodule

// File: rtl/fir_coef_bank.sv
// Double-buffered FIR coefficient store: host writes fill a shadow bank; the
// active bank is replaced atomically on swap_ok once every tap is written.
// Ports: clk, Reset (sync, active-high); PushCoef/CoefAddr/CoefI/CoefQ host
// write; swap_ok boundary strobe; coef_o, coef_valid, swap_pend, commit;
// coef_err only when COEF_BANK_ERR_EN is defined.
module fir_coef_bank
  import fir_structs::*;
(
  input  logic                      clk,
  input  logic                      Reset,
  input  logic                      PushCoef,
  input  logic [ADDR_W-1:0]         CoefAddr,
  input  logic signed [COEF_W-1:0]  CoefI,
  input  logic signed [COEF_W-1:0]  CoefQ,
  input  logic                      swap_ok,
  output Coef [NUM_COEF-1:0]        coef_o,
`ifdef COEF_BANK_ERR_EN
  output logic                      coef_err,
`endif
  output logic                      coef_valid,
  output logic                      swap_pend,
  output logic                      commit
);

  Coef [NUM_COEF-1:0] shadow, shadow_nxt, active;
  state_t             state, state_nxt;
  logic               wr_acc, do_commit, full_next;
  logic [NUM_COEF-1:0] mask;

  assign wr_acc = PushCoef && (CoefAddr < ADDR_W'(NUM_COEF));

  fir_coef_mask_tracker u_mask (
    .clk       (clk),
    .reset     (Reset),
    .wr        (wr_acc),
    .addr      (CoefAddr),
    .clr       (do_commit),
    .mask      (mask),
    .full_next (full_next)
  );

  // Shadow with this cycle's write merged in; also the commit source, so a
  // write coincident with swap_ok reaches the active bank.
  always_comb begin
    shadow_nxt = shadow;
    for (int k = 0; k < NUM_COEF; k++) begin
      if (wr_acc && (CoefAddr == ADDR_W'(k))) shadow_nxt[k] = {CoefI, CoefQ};
    end
  end

  always_comb begin
    state_nxt = state;
    do_commit = 1'b0;
    case (state)
      S_IDLE: if (wr_acc) state_nxt = full_next ? S_PEND : S_LOAD;
      S_LOAD: if (full_next) state_nxt = S_PEND;
      S_PEND: begin
        if (swap_ok) begin
          do_commit = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      shadow     <= '0;
      active     <= '0;
      coef_valid <= 1'b0;
    end else begin
      state  <= state_nxt;
      shadow <= shadow_nxt;
      if (do_commit) begin
        active     <= shadow_nxt;
        coef_valid <= 1'b1;
      end
    end
  end

`ifdef COEF_BANK_ERR_EN
  // Sticky: out-of-range write, or a boundary passing with a partial set.
  always_ff @(posedge clk) begin
    if (Reset)
      coef_err <= 1'b0;
    else if ((PushCoef && !wr_acc) || (swap_ok && state == S_LOAD))
      coef_err <= 1'b1;
  end
`endif

  assign coef_o    = active;
  assign swap_pend = (state == S_PEND);
  assign commit    = do_commit && !Reset;
  // mask is consumed inside the tracker via full_next; kept visible for debug.
  logic unused_mask;
  assign unused_mask = ^mask;

endmodule

// File: tb/tb_fir_coef_bank.sv
module tb_fir_coef_bank;
  import fir_structs::*;

  logic clk = 1'b0;
  logic Reset, PushCoef, swap_ok;
  logic [ADDR_W-1:0] CoefAddr;
  logic signed [COEF_W-1:0] CoefI, CoefQ;
  Coef [NUM_COEF-1:0] coef_o;
  logic coef_valid, swap_pend, commit;
`ifdef COEF_BANK_ERR_EN
  logic coef_err;
`endif

  always #5 clk = ~clk;

  fir_coef_bank dut (
    .clk(clk), .Reset(Reset), .PushCoef(PushCoef), .CoefAddr(CoefAddr),
    .CoefI(CoefI), .CoefQ(CoefQ), .swap_ok(swap_ok), .coef_o(coef_o),
`ifdef COEF_BANK_ERR_EN
    .coef_err(coef_err),
`endif
    .coef_valid(coef_valid), .swap_pend(swap_pend), .commit(commit)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: a set of written taps, shadow/active arrays, flags.
  Coef m_shadow [NUM_COEF];
  Coef m_active [NUM_COEF];
  bit  m_wr     [NUM_COEF];
  bit  m_valid, m_err;
  bit  exp_commit, obs_commit;

  function automatic bit all_written();
    int n = 0;
    for (int k = 0; k < NUM_COEF; k++) n += int'(m_wr[k]);
    return n == NUM_COEF;
  endfunction

  function automatic bit any_written();
    int n = 0;
    for (int k = 0; k < NUM_COEF; k++) n += int'(m_wr[k]);
    return n != 0;
  endfunction

  function automatic int bank_diffs();
    int n = 0;
    for (int k = 0; k < NUM_COEF; k++) if (coef_o[k] !== m_active[k]) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_COEF; k++) begin
      m_shadow[k] = '0; m_active[k] = '0; m_wr[k] = 1'b0;
    end
    m_valid = 1'b0; m_err = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    Reset = 1'b1; PushCoef = 1'b0; swap_ok = 1'b1; CoefAddr = '0; CoefI = '0; CoefQ = '0;
    #1 obs_commit = commit;
    exp_commit = 1'b0;
    @(posedge clk);
    model_reset();
    #1 Reset = 1'b0; swap_ok = 1'b0;
  endtask

  // Drive one cycle; records commit mid-cycle and advances the model at the edge.
  task automatic step(input bit push, input int addr, input logic [COEF_W-1:0] ci,
                      input logic [COEF_W-1:0] cq, input bit swap);
    bit pend_before, load_before;
    @(negedge clk);
    PushCoef = push; CoefAddr = ADDR_W'(addr); CoefI = ci; CoefQ = cq; swap_ok = swap;
    pend_before = all_written();
    load_before = any_written() && !pend_before;
    exp_commit  = pend_before && swap;
    #1 obs_commit = commit;
    @(posedge clk);
    if (push && addr < NUM_COEF) begin
      m_shadow[addr] = {ci, cq};
      m_wr[addr] = 1'b1;
    end else if (push) begin
      m_err = 1'b1;
    end
    if (swap && load_before) m_err = 1'b1;
    if (exp_commit) begin
      m_active = m_shadow;
      for (int k = 0; k < NUM_COEF; k++) m_wr[k] = 1'b0;
      m_valid = 1'b1;
    end
    #1 PushCoef = 1'b0; swap_ok = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (coef_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", coef_valid); end
    checks++; if (swap_pend !== 1'b0) begin errors++; $display("FAIL reset_pend: got %b expected 0", swap_pend); end
    checks++; if (commit !== 1'b0) begin errors++; $display("FAIL reset_commit: got %b expected 0", commit); end
    checks++; if (coef_o !== '0) begin errors++; $display("FAIL reset_coef: got %h expected 0", coef_o); end
`ifdef COEF_BANK_ERR_EN
    checks++; if (coef_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", coef_err); end
`endif
  endtask

  task automatic test_full_load();
    for (int a = 0; a < NUM_COEF; a++) begin
      step(1'b1, a, COEF_W'(a + 1), COEF_W'(-(a + 1)), 1'b0);
      checks++;
      if (swap_pend !== (a == NUM_COEF - 1)) begin
        errors++; $display("FAIL load_pend tap %0d: got %b expected %b", a, swap_pend, a == NUM_COEF - 1);
      end
    end
    checks++; if (coef_valid !== 1'b0) begin errors++; $display("FAIL load_valid: got %b expected 0", coef_valid); end
    checks++; if (coef_o !== '0) begin errors++; $display("FAIL load_coef: got %h expected 0", coef_o); end
  endtask

  task automatic test_commit();
    Coef exp5;
    exp5.I = 27'sd6; exp5.Q = -27'sd6;
    step(1'b0, 0, '0, '0, 1'b1);
    checks++; if (obs_commit !== 1'b1) begin errors++; $display("FAIL commit_pulse: got %b expected 1", obs_commit); end
    checks++; if (coef_o[5] !== exp5) begin errors++; $display("FAIL commit_tap5: got %h expected %h", coef_o[5], exp5); end
    checks++; if (bank_diffs() != 0) begin errors++; $display("FAIL commit_bank: got %0d differing taps expected 0", bank_diffs()); end
    checks++; if (coef_valid !== 1'b1) begin errors++; $display("FAIL commit_valid: got %b expected 1", coef_valid); end
    checks++; if (swap_pend !== 1'b0) begin errors++; $display("FAIL commit_pend: got %b expected 0", swap_pend); end
    step(1'b0, 0, '0, '0, 1'b1);
    checks++; if (obs_commit !== 1'b0) begin errors++; $display("FAIL commit_once: got %b expected 0", obs_commit); end
  endtask

  task automatic test_partial_swap();
    for (int a = 0; a < 10; a++) step(1'b1, a, COEF_W'($urandom), COEF_W'($urandom), 1'b0);
    step(1'b0, 0, '0, '0, 1'b1);
    checks++; if (obs_commit !== 1'b0) begin errors++; $display("FAIL partial_commit: got %b expected 0", obs_commit); end
    checks++; if (bank_diffs() != 0) begin errors++; $display("FAIL partial_bank: got %0d differing taps expected 0", bank_diffs()); end
    checks++; if (swap_pend !== 1'b0) begin errors++; $display("FAIL partial_pend: got %b expected 0", swap_pend); end
`ifdef COEF_BANK_ERR_EN
    checks++; if (coef_err !== 1'b1) begin errors++; $display("FAIL partial_err: got %b expected 1", coef_err); end
`endif
    for (int a = 10; a < NUM_COEF; a++) step(1'b1, a, COEF_W'($urandom), COEF_W'($urandom), 1'b0);
    checks++; if (swap_pend !== 1'b1) begin errors++; $display("FAIL partial_fill: got %b expected 1", swap_pend); end
  endtask

  task automatic test_forward();
    Coef exp3;
    exp3.I = 27'h7FFFFFF; exp3.Q = '0;
    step(1'b1, 3, 27'h7FFFFFF, '0, 1'b1);
    checks++; if (obs_commit !== 1'b1) begin errors++; $display("FAIL fwd_commit: got %b expected 1", obs_commit); end
    checks++; if (coef_o[3] !== exp3) begin errors++; $display("FAIL fwd_tap3: got %h expected %h", coef_o[3], exp3); end
    checks++; if (bank_diffs() != 0) begin errors++; $display("FAIL fwd_bank: got %0d differing taps expected 0", bank_diffs()); end
    // Mask must be empty now: 14 taps (skipping tap 0) must not reach pending.
    for (int a = 1; a < NUM_COEF; a++) step(1'b1, a, COEF_W'($urandom), COEF_W'($urandom), 1'b0);
    checks++; if (swap_pend !== 1'b0) begin errors++; $display("FAIL fwd_maskclr: got %b expected 0", swap_pend); end
    step(1'b1, 0, COEF_W'($urandom), COEF_W'($urandom), 1'b0);
    step(1'b0, 0, '0, '0, 1'b1);
    checks++; if (bank_diffs() != 0) begin errors++; $display("FAIL fwd_reload: got %0d differing taps expected 0", bank_diffs()); end
  endtask

  task automatic test_bad_addr();
    do_reset();
    step(1'b1, 20, COEF_W'($urandom), COEF_W'($urandom), 1'b0);
    checks++; if (swap_pend !== 1'b0) begin errors++; $display("FAIL bad_pend: got %b expected 0", swap_pend); end
`ifdef COEF_BANK_ERR_EN
    checks++; if (coef_err !== 1'b1) begin errors++; $display("FAIL bad_err: got %b expected 1", coef_err); end
`endif
    for (int a = 0; a < NUM_COEF; a++) step(1'b1, a, COEF_W'($urandom), COEF_W'($urandom), 1'b0);
    step(1'b1, 20, COEF_W'($urandom), COEF_W'($urandom), 1'b0);
    step(1'b1, 31, COEF_W'($urandom), COEF_W'($urandom), 1'b0);
    step(1'b0, 0, '0, '0, 1'b1);
    checks++; if (bank_diffs() != 0) begin errors++; $display("FAIL bad_shadow: got %0d differing taps expected 0", bank_diffs()); end
`ifdef COEF_BANK_ERR_EN
    checks++; if (coef_err !== 1'b1) begin errors++; $display("FAIL bad_sticky: got %b expected 1", coef_err); end
`endif
  endtask

  task automatic test_reset_midload();
    for (int a = 0; a < 7; a++) step(1'b1, a, COEF_W'($urandom), COEF_W'($urandom), 1'b0);
    do_reset();
    checks++; if (coef_o !== '0 || coef_valid !== 1'b0 || swap_pend !== 1'b0) begin
      errors++; $display("FAIL midrst_outs: got valid=%b pend=%b coef_nz=%b expected all 0", coef_valid, swap_pend, coef_o != '0);
    end
    for (int a = 7; a < NUM_COEF; a++) step(1'b1, a, COEF_W'($urandom), COEF_W'($urandom), 1'b0);
    checks++; if (swap_pend !== 1'b0) begin errors++; $display("FAIL midrst_mask: got %b expected 0", swap_pend); end
    for (int a = 0; a < 7; a++) step(1'b1, a, COEF_W'($urandom), COEF_W'($urandom), 1'b0);
    step(1'b0, 0, '0, '0, 1'b1);
    checks++; if (obs_commit !== 1'b1) begin errors++; $display("FAIL midrst_commit: got %b expected 1", obs_commit); end
    checks++; if (bank_diffs() != 0) begin errors++; $display("FAIL midrst_bank: got %0d differing taps expected 0", bank_diffs()); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step(1'b1 && ($urandom_range(0, 3) != 0), int'($urandom_range(0, 17)),
           COEF_W'($urandom), COEF_W'($urandom), $urandom_range(0, 5) == 0);
      checks++;
      if (obs_commit !== exp_commit || swap_pend !== all_written() || coef_valid !== m_valid || bank_diffs() != 0) begin
        errors++;
        $display("FAIL random cyc %0d: commit=%b/%b pend=%b/%b valid=%b/%b taps_off=%0d (got/expected)",
                 n, obs_commit, exp_commit, swap_pend, all_written(), coef_valid, m_valid, bank_diffs());
      end
`ifdef COEF_BANK_ERR_EN
      checks++; if (coef_err !== m_err) begin errors++; $display("FAIL random_err cyc %0d: got %b expected %b", n, coef_err, m_err); end
`endif
    end
  endtask

  initial begin
    Reset = 1'b1; PushCoef = 1'b0; swap_ok = 1'b0; CoefAddr = '0; CoefI = '0; CoefQ = '0;
    model_reset();
    test_reset();
    test_full_load();
    test_commit();
    test_partial_swap();
    test_forward();
    test_bad_addr();
    test_reset_midload();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
